// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard/forwarding controller.
// Shadow entries carry register fields at a fixed maximum width so the struct stays parameter-free.
package haz_pkg;

  localparam int unsigned RF_W_MAX = 8;
  localparam int unsigned FWD_RF   = 0;

  typedef struct packed {
    logic                valid;
    logic [RF_W_MAX-1:0] rd;
    logic                reg_write;
    logic                is_load;
    logic [RF_W_MAX-1:0] rs1;
    logic [RF_W_MAX-1:0] rs2;
  } haz_entry_t;

  typedef enum logic [1:0] {
    NONE,
    LU_STALL,
    FLUSH,
    FREEZE
  } haz_action_e;

  // An entry that will really update a non-zero architectural register.
  function automatic logic is_writer(haz_entry_t e);
    return e.valid && e.reg_write && (e.rd != '0);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
// Priority matcher for one EX source register: picks the youngest stage able to forward it.
module fwd_select
  import haz_pkg::*;
#(
  parameter int unsigned N     = 3,
  parameter int unsigned FWD_W = 2
) (
  input  haz_entry_t [N-1:0] ents,
  input  logic [RF_W_MAX-1:0] src,
  input  logic                en,
  output logic [FWD_W-1:0]    sel
);

  logic [N-1:1] hit;
  logic         unused_bits;

  // Loads can only forward once their data exists, i.e. from WB.
  for (genvar k = 1; k < N; k++) begin : g_hit
    assign hit[k] = is_writer(ents[k]) && (ents[k].rd == src) &&
                    (!ents[k].is_load || (k == N - 1));
  end

  // Scan oldest to youngest so the youngest match wins.
  always_comb begin
    sel = FWD_W'(FWD_RF);
    for (int k = N - 1; k >= 1; k--) begin
      if (hit[k]) sel = FWD_W'(k);
    end
    if (!en) sel = FWD_W'(FWD_RF);
  end

  always_comb begin
    unused_bits = ^ents[0];
    for (int k = 1; k < N; k++) begin
      unused_bits = unused_bits ^ (^{ents[k].rs1, ents[k].rs2});
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for the in-order pipeline with MEM_STAGES memory stages.
// Optional saturating perf counters when HAZ_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
  import haz_pkg::*;
#(
  parameter  int unsigned MEM_STAGES = 1,
  parameter  int unsigned RF_ADDR_W  = 5,
  parameter  int unsigned CNT_W      = 32,
  localparam int unsigned FWD_W      = $clog2(MEM_STAGES + 2)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic [RF_ADDR_W-1:0] id_rs1,
  input  logic [RF_ADDR_W-1:0] id_rs2,
  input  logic                 id_rs1_used,
  input  logic                 id_rs2_used,
  input  logic [RF_ADDR_W-1:0] id_rd,
  input  logic                 id_reg_write,
  input  logic                 id_mem_read,
  input  logic                 ex_br_taken,
  input  logic                 mem_busy,
  output logic                 pc_hold,
  output logic                 if_id_hold,
  output logic                 if_id_flush,
  output logic                 id_ex_bubble,
  output logic                 pipe_freeze,
  output logic [FWD_W-1:0]     fwd_a_sel,
  output logic [FWD_W-1:0]     fwd_b_sel
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]     lu_stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt,
  output logic [CNT_W-1:0]     freeze_cnt
`endif
);

  localparam int unsigned N = MEM_STAGES + 2;

  haz_entry_t [N-1:0]      s;
  haz_entry_t              id_entry;
  haz_action_e             action;
  logic [MEM_STAGES-1:0]   lu_hit;
  logic                    lu;
  logic                    fwd_en;

  always_comb begin
    id_entry           = '0;
    id_entry.valid     = id_valid;
    id_entry.rd        = RF_W_MAX'(id_rd);
    id_entry.reg_write = id_reg_write;
    id_entry.is_load   = id_mem_read;
    id_entry.rs1       = RF_W_MAX'(id_rs1);
    id_entry.rs2       = RF_W_MAX'(id_rs2);
  end

  // A load still short of WB cannot feed the ID instruction when it reaches EX.
  for (genvar j = 0; j < MEM_STAGES; j++) begin : g_lu
    assign lu_hit[j] = is_writer(s[j]) && s[j].is_load &&
                       ((id_rs1_used && (s[j].rd == id_entry.rs1)) ||
                        (id_rs2_used && (s[j].rd == id_entry.rs2)));
  end
  assign lu = id_valid && (|lu_hit);

  // Arbitration: freeze > flush > load-use; flush wins because the stalled instruction is dead.
  always_comb begin
    action = NONE;
    if (reset)            action = NONE;
    else if (mem_busy)    action = FREEZE;
    else if (ex_br_taken) action = FLUSH;
    else if (lu)          action = LU_STALL;
  end

  always_comb begin
    pc_hold      = 1'b0;
    if_id_hold   = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_freeze  = 1'b0;
    case (action)
      FREEZE: begin
        pc_hold     = 1'b1;
        if_id_hold  = 1'b1;
        pipe_freeze = 1'b1;
      end
      FLUSH: begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end
      LU_STALL: begin
        pc_hold      = 1'b1;
        if_id_hold   = 1'b1;
        id_ex_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  // Shadow pipeline: s[0] is EX, s[N-1] is WB.
  always_ff @(posedge clk) begin
    if (reset) begin
      s <= '0;
    end else begin
      case (action)
        FREEZE:          s <= s;
        FLUSH, LU_STALL: s <= {s[N-2:0], haz_entry_t'('0)};
        default:         s <= {s[N-2:0], id_entry};
      endcase
    end
  end

  assign fwd_en = s[0].valid && !reset;

  fwd_select #(.N(N), .FWD_W(FWD_W)) u_fwd_a (
    .ents (s),
    .src  (s[0].rs1),
    .en   (fwd_en),
    .sel  (fwd_a_sel)
  );

  fwd_select #(.N(N), .FWD_W(FWD_W)) u_fwd_b (
    .ents (s),
    .src  (s[0].rs2),
    .en   (fwd_en),
    .sel  (fwd_b_sel)
  );

`ifdef HAZ_PERF_CNT_EN
  // Saturating event counters for the winning action of each cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      lu_stall_cnt <= '0;
      flush_cnt    <= '0;
      freeze_cnt   <= '0;
    end else begin
      if (action == LU_STALL && lu_stall_cnt != '1) lu_stall_cnt <= lu_stall_cnt + CNT_W'(1);
      if (action == FLUSH    && flush_cnt    != '1) flush_cnt    <= flush_cnt + CNT_W'(1);
      if (action == FREEZE   && freeze_cnt   != '1) freeze_cnt   <= freeze_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: one instance with MEM_STAGES=1 and one with MEM_STAGES=2.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1_used;
    logic       rs2_used;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
    logic       br;
    logic       busy;
  } in_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  in_t  in1, in2;
  logic ph1, ih1, fl1, bb1, fz1;
  logic ph2, ih2, fl2, bb2, fz2;
  logic [1:0] fa1, fb1, fa2, fb2;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] lu_c1, fl_c1, fz_c1, lu_c2, fl_c2, fz_c2;
`endif

  int total = 0;
  int bad   = 0;

  pipe_hazard_ctrl #(.MEM_STAGES(1)) dut1 (
    .clk(clk), .reset(reset),
    .id_valid(in1.valid), .id_rs1(in1.rs1), .id_rs2(in1.rs2),
    .id_rs1_used(in1.rs1_used), .id_rs2_used(in1.rs2_used), .id_rd(in1.rd),
    .id_reg_write(in1.reg_write), .id_mem_read(in1.mem_read),
    .ex_br_taken(in1.br), .mem_busy(in1.busy),
    .pc_hold(ph1), .if_id_hold(ih1), .if_id_flush(fl1), .id_ex_bubble(bb1),
    .pipe_freeze(fz1), .fwd_a_sel(fa1), .fwd_b_sel(fb1)
`ifdef HAZ_PERF_CNT_EN
    , .lu_stall_cnt(lu_c1), .flush_cnt(fl_c1), .freeze_cnt(fz_c1)
`endif
  );

  pipe_hazard_ctrl #(.MEM_STAGES(2)) dut2 (
    .clk(clk), .reset(reset),
    .id_valid(in2.valid), .id_rs1(in2.rs1), .id_rs2(in2.rs2),
    .id_rs1_used(in2.rs1_used), .id_rs2_used(in2.rs2_used), .id_rd(in2.rd),
    .id_reg_write(in2.reg_write), .id_mem_read(in2.mem_read),
    .ex_br_taken(in2.br), .mem_busy(in2.busy),
    .pc_hold(ph2), .if_id_hold(ih2), .if_id_flush(fl2), .id_ex_bubble(bb2),
    .pipe_freeze(fz2), .fwd_a_sel(fa2), .fwd_b_sel(fb2)
`ifdef HAZ_PERF_CNT_EN
    , .lu_stall_cnt(lu_c2), .flush_cnt(fl_c2), .freeze_cnt(fz_c2)
`endif
  );

  function automatic in_t idle();
    return '0;
  endfunction

  function automatic in_t alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    in_t t = '0;
    t.valid = 1'b1; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2;
    t.rs1_used = 1'b1; t.rs2_used = 1'b1; t.reg_write = 1'b1;
    return t;
  endfunction

  function automatic in_t ld(input logic [4:0] rd, input logic [4:0] rs1);
    in_t t = '0;
    t.valid = 1'b1; t.rd = rd; t.rs1 = rs1; t.rs1_used = 1'b1;
    t.reg_write = 1'b1; t.mem_read = 1'b1;
    return t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Control vector order: {pc_hold, if_id_hold, if_id_flush, id_ex_bubble, pipe_freeze}
  task automatic chk_ctl1(input string tag, input logic [4:0] exp);
    chk(tag, 32'({ph1, ih1, fl1, bb1, fz1}), 32'(exp));
  endtask

  task automatic chk_ctl2(input string tag, input logic [4:0] exp);
    chk(tag, 32'({ph2, ih2, fl2, bb2, fz2}), 32'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input in_t a);
    in1 = a;
    #1;
  endtask

  task automatic drive2(input in_t a);
    in2 = a;
    #1;
  endtask

  initial begin
    in_t t;
    reset = 1'b1;
    in1 = idle();
    in2 = idle();
    repeat (2) tick();
    chk_ctl1("rst_ctl", 5'b00000);
    chk("rst_fwd_a", 32'(fa1), 32'd0);
    chk("rst_fwd_b", 32'(fb1), 32'd0);
    reset = 1'b0;

    // lw x5 ; add x6,x5,x1 with one memory stage
    drive1(ld(5'd5, 5'd2));
    chk_ctl1("lw_issue", 5'b00000);
    tick();
    drive1(alu(5'd6, 5'd5, 5'd1));
    chk_ctl1("lu1_stall", 5'b11010);
    tick();
    #1;
    chk_ctl1("lu1_release", 5'b00000);
    tick();
    drive1(idle());
    chk("lu1_fwd_a", 32'(fa1), 32'd2);
    chk("lu1_fwd_b", 32'(fb1), 32'd0);
    repeat (3) tick();

    // add x3 ; sub x4,x3,x3 ; or x5,x3,x4
    drive1(alu(5'd3, 5'd1, 5'd2));
    tick();
    drive1(alu(5'd4, 5'd3, 5'd3));
    chk("alu_add_a", 32'(fa1), 32'd0);
    tick();
    drive1(alu(5'd5, 5'd3, 5'd4));
    chk("alu_sub_a", 32'(fa1), 32'd1);
    chk("alu_sub_b", 32'(fb1), 32'd1);
    chk_ctl1("alu_no_stall", 5'b00000);
    tick();
    drive1(idle());
    chk("alu_or_a", 32'(fa1), 32'd2);
    chk("alu_or_b", 32'(fb1), 32'd1);
    repeat (3) tick();

    // Writes to x0 never stall or forward
    drive1(ld(5'd0, 5'd2));
    tick();
    drive1(alu(5'd7, 5'd0, 5'd0));
    chk_ctl1("x0_no_lu", 5'b00000);
    tick();
    drive1(alu(5'd0, 5'd1, 5'd2));
    tick();
    drive1(alu(5'd8, 5'd0, 5'd0));
    tick();
    drive1(idle());
    chk("x0_fwd_a", 32'(fa1), 32'd0);
    chk("x0_fwd_b", 32'(fb1), 32'd0);
    repeat (3) tick();

    // Branch flush together with load-use, then a 3-cycle freeze
    drive1(ld(5'd5, 5'd2));
    tick();
    t = alu(5'd6, 5'd5, 5'd1);
    t.br = 1'b1;
    drive1(t);
    chk_ctl1("flush_lu", 5'b00110);
    tick();
    drive1(alu(5'd6, 5'd5, 5'd1));
    chk_ctl1("post_flush", 5'b00000);
    tick();
    for (int i = 0; i < 3; i++) begin
      t = alu(5'd9, 5'd9, 5'd9);
      t.busy = 1'b1;
      t.br = 1'b1;
      drive1(t);
      chk_ctl1("freeze", 5'b11001);
      chk("freeze_fwd_a", 32'(fa1), 32'd2);
      tick();
    end
    drive1(idle());
    chk_ctl1("freeze_end", 5'b00000);
    chk("freeze_held_a", 32'(fa1), 32'd2);
    repeat (3) tick();

    // Reset in the middle of a load-use stall
    drive1(ld(5'd5, 5'd2));
    tick();
    drive1(alu(5'd6, 5'd5, 5'd1));
    chk_ctl1("rst_pre_stall", 5'b11010);
    reset = 1'b1;
    tick();
    chk_ctl1("rst_mid_stall", 5'b00000);
    chk("rst_mid_fwd_a", 32'(fa1), 32'd0);
`ifdef HAZ_PERF_CNT_EN
    chk("rst_lu_cnt", lu_c1, 32'd0);
    chk("rst_flush_cnt", fl_c1, 32'd0);
    chk("rst_freeze_cnt", fz_c1, 32'd0);
`endif
    reset = 1'b0;
    #1;
    chk_ctl1("rst_cleared", 5'b00000);
    drive1(idle());
    repeat (2) tick();

    // Two memory stages: lw x5 ; add x6,x5,x1 stalls twice
    drive2(ld(5'd5, 5'd2));
    tick();
    drive2(alu(5'd6, 5'd5, 5'd1));
    chk_ctl2("ms2_stall1", 5'b11010);
    tick();
    #1;
    chk_ctl2("ms2_stall2", 5'b11010);
    tick();
    #1;
    chk_ctl2("ms2_release", 5'b00000);
    tick();
    drive2(idle());
    chk("ms2_fwd_a", 32'(fa2), 32'd3);
    chk("ms2_fwd_b", 32'(fb2), 32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
